// File: rtl/encode_stage_sequencer.sv
// Control sequencer for the encode CNN dataflow chain (castIn .. castOut).
// Drives each stage's ap_ctrl_chain handshake, bounds channel occupancy and watches for stalls.
module encode_stage_sequencer #(
  parameter int unsigned NUM_STAGES  = 8,
  parameter int unsigned BUF_DEPTH   = 2,
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned STALL_LIMIT = 65535
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [FRAME_W-1:0]    frame_count,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_continue,
  output logic                  deadlock,
  output logic [FRAME_W-1:0]    frames_done
);

  localparam int unsigned LAST    = NUM_STAGES - 1;
  localparam int unsigned OCC_W   = 3;
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [OCC_W-1:0]   DEPTH = OCC_W'(BUF_DEPTH);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   total_q, total_d;
  logic [FRAME_W-1:0]   started_q   [NUM_STAGES];
  logic [FRAME_W-1:0]   started_d   [NUM_STAGES];
  logic [FRAME_W-1:0]   completed_q [NUM_STAGES];
  logic [FRAME_W-1:0]   completed_d [NUM_STAGES];
  logic [OCC_W-1:0]     occ_q       [NUM_STAGES-1];
  logic [OCC_W-1:0]     occ_d       [NUM_STAGES-1];
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 deadlock_q, deadlock_d;

  logic [NUM_STAGES-1:0] up_avail;
  logic [NUM_STAGES-1:0] down_room;
  logic [NUM_STAGES-1:0] start_fire;
  logic [NUM_STAGES-1:0] done_fire;

  // Channel status seen by each stage: a frame waiting upstream, room downstream.
  always_comb begin
    up_avail        = '0;
    down_room       = '0;
    up_avail[0]     = 1'b1;
    down_room[LAST] = 1'b1;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      up_avail[i] = (occ_q[i-1] != '0);
    end
    for (int unsigned i = 0; i < LAST; i++) begin
      down_room[i] = (occ_q[i] < DEPTH);
    end
  end

  // Per-stage handshake, only live while a batch is running.
  always_comb begin
    stage_start    = '0;
    stage_continue = '0;
    if (state_q == S_RUN) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_start[i] = (started_q[i] == completed_q[i]) &&
                         (started_q[i] < total_q) && up_avail[i];
      end
      stage_continue = down_room;
    end
    start_fire = stage_start & stage_ready;
    done_fire  = stage_done & stage_continue;
  end

  // Next-state, counters, channel occupancy and stall watchdog.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    started_d   = started_q;
    completed_d = completed_q;
    occ_d       = occ_q;
    stall_d     = stall_q;
    deadlock_d  = deadlock_q;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          total_d    = frame_count;
          stall_d    = '0;
          deadlock_d = 1'b0;
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            started_d[i]   = '0;
            completed_d[i] = '0;
          end
          for (int unsigned i = 0; i < LAST; i++) begin
            occ_d[i] = '0;
          end
          state_d = (frame_count == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
          started_d[i]   = started_q[i] + FRAME_W'(start_fire[i]);
          completed_d[i] = completed_q[i] + FRAME_W'(done_fire[i]);
        end
        // A completion into a channel and a start out of it in one cycle cancel.
        for (int unsigned i = 0; i < LAST; i++) begin
          occ_d[i] = occ_q[i] + OCC_W'(done_fire[i]) - OCC_W'(start_fire[i+1]);
        end
        if ((start_fire != '0) || (done_fire != '0)) begin
          stall_d = '0;
        end else if (stall_q != LIMIT) begin
          stall_d = stall_q + STALL_W'(1);
        end
        if (stall_d == LIMIT) begin
          deadlock_d = 1'b1;
        end
        if (completed_q[LAST] == total_q) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        stall_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      stall_q    <= '0;
      deadlock_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        started_q[i]   <= '0;
        completed_q[i] <= '0;
      end
      for (int unsigned i = 0; i < LAST; i++) begin
        occ_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      stall_q     <= stall_d;
      deadlock_q  <= deadlock_d;
      started_q   <= started_d;
      completed_q <= completed_d;
      occ_q       <= occ_d;
    end
  end

  // An empty batch reports ready and done together in its single FINISH cycle.
  assign ap_idle     = (state_q == S_IDLE);
  assign ap_done     = (state_q == S_FINISH);
  assign ap_ready    = ((state_q == S_RUN) && start_fire[0] &&
                        (started_q[0] == total_q - FRAME_W'(1))) ||
                       ((state_q == S_FINISH) && (total_q == '0));
  assign deadlock    = deadlock_q;
  assign frames_done = completed_q[LAST];

endmodule

// File: tb/tb_encode_stage_sequencer.sv
// Bench for encode_stage_sequencer: behavioural stage responders, a cycle model of the
// sequencer, a table of batch scenarios and hand sequences for stall and mid-batch reset.
module tb_encode_stage_sequencer;

  localparam int NS = 8;
  localparam int FW = 16;
  localparam int BD = 2;
  localparam int SL = 20;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic [FW-1:0] frame_count = '0;
  logic          ap_idle, ap_ready, ap_done, deadlock;
  logic [NS-1:0] stage_start, stage_continue;
  logic [NS-1:0] ready_en = '1;
  logic [NS-1:0] done_r;
  logic [FW-1:0] frames_done;

  int lat [NS];
  int cnt [NS];

  always #5 ap_clk = ~ap_clk;

  encode_stage_sequencer #(
    .NUM_STAGES (NS),
    .BUF_DEPTH  (BD),
    .FRAME_W    (FW),
    .STALL_LIMIT(SL)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .frame_count   (frame_count),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .stage_start   (stage_start),
    .stage_ready   (ready_en),
    .stage_done    (done_r),
    .stage_continue(stage_continue),
    .deadlock      (deadlock),
    .frames_done   (frames_done)
  );

  // Stage responders: done rises lat cycles after the start fire and holds until continued.
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      done_r <= '0;
      for (int i = 0; i < NS; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (stage_start[i] && ready_en[i]) begin
          if (lat[i] <= 1) done_r[i] <= 1'b1;
          else cnt[i] <= lat[i] - 1;
        end else if (cnt[i] != 0) begin
          if (cnt[i] == 1) done_r[i] <= 1'b1;
          cnt[i] <= cnt[i] - 1;
        end
        if (done_r[i] && stage_continue[i]) done_r[i] <= 1'b0;
      end
    end
  end

  typedef struct {
    int fc;
    int lat;
    int slow_stage;
    int slow_lat;
    int exp_fd;
    int exp_ready_cyc;
    int exp_done_cyc;
    int exp_dl;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic run_m = 1'b0, fin_m = 1'b0, dl_m = 1'b0;
  int mtot = 0, stall_m = 0;
  int ms [NS];
  int mc [NS];
  int mocc [NS];
  int aocc [NS];
  // Per-batch observations
  int rel = -1, ready_cnt = 0, done_cnt = 0, ready_cyc = -1, done_cyc = -1, dl_cyc = -1;
  int sc [NS];
  int cc [NS];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    run_m = 1'b0; fin_m = 1'b0; dl_m = 1'b0; mtot = 0; stall_m = 0;
    for (int i = 0; i < NS; i++) begin
      ms[i] = 0; mc[i] = 0; mocc[i] = 0; aocc[i] = 0;
    end
  endtask

  // Evaluated on the falling edge: compare outputs, then advance the model to the next rising edge.
  task automatic monitor();
    logic [NS-1:0] es, ec, sf, cf, asf, acf;
    logic er, idle_m, up, occ_ok;
    if (!ap_rst_n) clear_model();
    es = '0;
    ec = '0;
    for (int i = 0; i < NS; i++) begin
      up = (i == 0);
      if (i > 0) up = (mocc[i-1] > 0);
      if (run_m) begin
        es[i] = (ms[i] == mc[i]) && (ms[i] < mtot) && up;
        ec[i] = (i == NS - 1) || (mocc[i] < BD);
      end
    end
    idle_m = !run_m && !fin_m;
    er = (run_m && es[0] && ready_en[0] && (ms[0] == mtot - 1)) || (fin_m && mtot == 0);
    chk("stage_start", longint'(stage_start), longint'(es));
    chk("stage_continue", longint'(stage_continue), longint'(ec));
    chk("ap_ready", longint'(ap_ready), longint'(er));
    chk("ap_done", longint'(ap_done), longint'(fin_m));
    chk("ap_idle", longint'(ap_idle), longint'(idle_m));
    chk("deadlock", longint'(deadlock), longint'(dl_m));
    chk("frames_done", longint'(frames_done), longint'(mc[NS-1]));

    asf = stage_start & ready_en;
    acf = done_r & stage_continue;
    occ_ok = 1'b1;
    for (int i = 0; i < NS - 1; i++) begin
      aocc[i] += int'(acf[i]) - int'(asf[i+1]);
      if (aocc[i] < 0 || aocc[i] > BD) occ_ok = 1'b0;
    end
    chk("occ_bound", longint'(occ_ok), 1);

    if (rel >= 0) rel++;
    for (int i = 0; i < NS; i++) begin
      sc[i] += int'(asf[i]);
      cc[i] += int'(acf[i]);
    end
    if (ap_ready) begin
      ready_cnt++;
      if (ready_cyc < 0) ready_cyc = rel;
    end
    if (ap_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = rel;
    end
    if (deadlock && dl_cyc < 0) dl_cyc = rel;

    sf = es & ready_en;
    cf = done_r & ec;
    if (ap_rst_n) begin
      if (idle_m) begin
        if (ap_start) begin
          clear_model();
          mtot = int'(frame_count);
          run_m = (frame_count != '0);
          fin_m = (frame_count == '0);
          rel = 0; ready_cnt = 0; done_cnt = 0;
          ready_cyc = -1; done_cyc = -1; dl_cyc = -1;
          for (int i = 0; i < NS; i++) begin
            sc[i] = 0; cc[i] = 0;
          end
        end
      end else if (run_m) begin
        if (mc[NS-1] == mtot) begin
          run_m = 1'b0;
          fin_m = 1'b1;
        end
        for (int i = 0; i < NS; i++) begin
          ms[i] += int'(sf[i]);
          mc[i] += int'(cf[i]);
          if (i < NS - 1) mocc[i] += int'(cf[i]) - int'(sf[i+1]);
        end
        if ((sf | cf) == '0) begin
          if (stall_m < SL) stall_m++;
          if (stall_m == SL) dl_m = 1'b1;
        end else begin
          stall_m = 0;
        end
      end else begin
        fin_m = 1'b0;
        stall_m = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
    monitor();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    for (int i = 0; i < NS; i++) lat[i] = v.lat;
    if (v.slow_stage >= 0) lat[v.slow_stage] = v.slow_lat;
    ap_start = 1'b1;
    frame_count = FW'(v.fc);
    tick();
    ap_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("batch_timeout", longint'(done_cnt > 0), 1);
    repeat (3) tick();
    chk("frames_done_end", longint'(frames_done), longint'(v.exp_fd));
    chk("ready_cycle", longint'(ready_cyc), longint'(v.exp_ready_cyc));
    chk("done_cycle", longint'(done_cyc), longint'(v.exp_done_cyc));
    chk("ready_pulses", longint'(ready_cnt), 1);
    chk("done_pulses", longint'(done_cnt), 1);
    chk("deadlock_end", longint'(deadlock), longint'(v.exp_dl));
    chk("idle_end", longint'(ap_idle), 1);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("starts_stage%0d", i), longint'(sc[i]), longint'(v.fc));
      chk($sformatf("completes_stage%0d", i), longint'(cc[i]), longint'(v.fc));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stage_start"}, longint'(stage_start), 0);
    chk({tag, "_stage_continue"}, longint'(stage_continue), 0);
    chk({tag, "_ap_idle"}, longint'(ap_idle), 1);
    chk({tag, "_ap_ready"}, longint'(ap_ready), 0);
    chk({tag, "_ap_done"}, longint'(ap_done), 0);
    chk({tag, "_deadlock"}, longint'(deadlock), 0);
    chk({tag, "_frames_done"}, longint'(frames_done), 0);
  endtask

  vec_t vecs [5];

  initial begin
    // fc, lat, slow stage, slow lat, frames_done, ready cycle, done cycle, deadlock
    vecs[0] = '{1, 3, -1, 0, 1, 1, 34, 0};
    vecs[1] = '{5, 1, -1, 0, 5, 9, 26, 0};
    vecs[2] = '{3, 2, -1, 0, 3, 7, 32, 0};
    vecs[3] = '{4, 1, 3, 50, 4, 7, 220, 1};
    vecs[4] = '{0, 1, -1, 0, 0, 1, 1, 0};
    for (int i = 0; i < NS; i++) lat[i] = 1;
    clear_model();

    repeat (2) tick();
    check_reset_outputs("por");
    ap_rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Stage 5 never ready: watchdog fires 20 idle cycles after the last handshake (cycle 12).
    begin
      int n;
      for (int i = 0; i < NS; i++) lat[i] = 1;
      ready_en = '1;
      ready_en[5] = 1'b0;
      ap_start = 1'b1;
      frame_count = FW'(2);
      tick();
      ap_start = 1'b0;
      n = 0;
      while (rel < 45 && n < 200) begin
        tick();
        n++;
      end
      chk("dl_cycle", longint'(dl_cyc), 33);
      chk("dl_sticky", longint'(deadlock), 1);
      chk("dl_still_run", longint'(ap_idle), 0);
      chk("dl_stage5_starts", longint'(sc[5]), 0);
      ap_rst_n = 1'b0;
      #1;
      check_reset_outputs("dl_rst");
      repeat (2) tick();
      ap_rst_n = 1'b1;
      ready_en = '1;
      tick();
    end

    // Reset while frame 2 of 5 is in flight, then a clean 3-frame batch.
    begin
      int n;
      for (int i = 0; i < NS; i++) lat[i] = 1;
      ap_start = 1'b1;
      frame_count = FW'(5);
      tick();
      ap_start = 1'b0;
      n = 0;
      while (rel < 5 && n < 100) begin
        tick();
        n++;
      end
      chk("mid_stage0_starts", longint'(sc[0]), 3);
      ap_rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      repeat (2) tick();
      chk("mid_no_done", longint'(done_cnt), 0);
      ap_rst_n = 1'b1;
      tick();
      run_vec('{3, 1, -1, 0, 3, 5, 22, 0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_stage_sequencer.md
Name: encode_stage_sequencer

Overview:
- Central control FSM for the encode CNN dataflow chain: castIn, conv1, pool1, conv2, pool2, conv3, pool3, castOut.
- Drives each stage's ap_ctrl_chain handshake (start/ready/done/continue).
- Enforces the depth of each inter-stage frame buffer.
- Counts frames until the requested batch completes.
- Includes a stall watchdog that flags a sticky deadlock when no stage handshake occurs for STALL_LIMIT cycles.

Parameters:
- NUM_STAGES, 8, number of chained stages; index 0 = castIn, NUM_STAGES-1 = castOut.
- BUF_DEPTH, 2, frames each inter-stage channel can hold (ping-pong); legal range 1..7.
- FRAME_W, 16, width of frame counters.
- STALL_LIMIT, 65535, idle-handshake cycles in RUN before deadlock asserts; must be >= 1.

Ports:
- ap_clk, in, 1, clock.
- ap_rst_n, in, 1, reset; asynchronous assert, active-low.
- ap_start, in, 1, batch start request; sampled in IDLE only.
- frame_count, in, FRAME_W, frames in batch; latched when ap_start is accepted.
- ap_idle, out, 1, high in IDLE.
- ap_ready, out, 1, one-cycle pulse when stage 0 accepts the last frame.
- ap_done, out, 1, one-cycle pulse when the last stage completes the last frame.
- stage_start, out, NUM_STAGES, per-stage ap_start.
- stage_ready, in, NUM_STAGES, per-stage ap_ready.
- stage_done, in, NUM_STAGES, per-stage ap_done.
- stage_continue, out, NUM_STAGES, per-stage ap_continue.
- deadlock, out, 1, sticky stall flag.
- frames_done, out, FRAME_W, completed frames of the last stage in the current batch.

Behaviour:
- Reset (async, ap_rst_n=0):
  - State = IDLE.
  - All counters, occupancies and the stall counter = 0.
  - stage_start = 0, stage_continue = 0, ap_ready = ap_done = deadlock = 0, ap_idle = 1, frames_done = 0.
  - Reset in mid-batch aborts the batch with no ap_done.
- FSM states IDLE, RUN, FINISH:
  - IDLE→RUN when ap_start=1 and frame_count≠0. Latch total=frame_count; clear per-stage counters, frames_done and deadlock.
  - IDLE→FINISH when ap_start=1 and frame_count=0. ap_ready and ap_done then pulse together in the FINISH cycle.
  - RUN→FINISH on the cycle after the last stage's completion count reaches total.
  - FINISH→IDLE unconditionally after one cycle. ap_done=1 only in FINISH.
  - ap_start is ignored outside IDLE.
- Per-stage state (i = 0..NUM_STAGES-1):
  - started[i] and completed[i], each FRAME_W bits.
  - busy[i] = started[i]≠completed[i]; at most one frame outstanding per stage.
  - occ[i] is 3 bits, for i < NUM_STAGES-1: frames in the channel after stage i.
- Start rule, RUN only:
  - stage_start[i] = !busy[i] && started[i]<total && (i==0 || occ[i-1]>0).
  - A start fires on stage_start[i]&stage_ready[i]. It increments started[i] and, for i>0, decrements occ[i-1].
  - stage_start is combinational from registered state and drops the cycle after the fire.
- Continue rule:
  - stage_continue[i] = (i==NUM_STAGES-1) || occ[i]<BUF_DEPTH.
  - Completion fires on stage_done[i]&stage_continue[i]. It increments completed[i] and, for i<NUM_STAGES-1, increments occ[i].
  - stage_continue is 0 in IDLE/FINISH.
- Simultaneous events:
  - Completion of stage i and start of stage i+1 in the same cycle leave occ[i] unchanged.
  - occ never exceeds BUF_DEPTH and never goes below 0; the bench asserts this.
- ap_ready pulses for exactly one cycle on the cycle stage 0's start fires with started[0]==total-1.
- frames_done = completed[NUM_STAGES-1]. It holds its value in IDLE until the next accepted ap_start.
- Watchdog:
  - In RUN, stall counter increments each cycle with no start fire and no completion fire on any stage.
  - It clears on any fire.
  - When the counter reaches STALL_LIMIT, deadlock=1. The counter saturates; deadlock remains 1 through FINISH/IDLE until the next accepted ap_start or reset.
  - Deadlock does not alter sequencing.
- Latency:
  - With stages responding ready on the same cycle, stage 0's start asserts the first cycle of RUN (cycle after ap_start accept).
  - Stage i+1 can start the cycle after stage i's completion fires.

Test Plan:
- NUM_STAGES=8, frame_count=1, each stage asserts ready immediately and done 3 cycles after start → starts ripple stage 0..7 in order, one frame each; ap_ready pulses in the first RUN cycle; ap_done pulses once; frames_done=1; ap_idle returns to 1 after FINISH.
- frame_count=5, all stages 1-cycle latency → every stage started and completed exactly 5 times; occ ≤ 2 throughout; ap_done pulses exactly once; frames_done=5.
- frame_count=4, stage 3 holds stage_done low for 50 cycles per frame → stage_continue[2] drops when occ[2]=2; stage 2 sees done unacknowledged; no frame lost; batch completes with frames_done=4.
- ap_start with frame_count=0 → FINISH next cycle with ap_ready=ap_done=1 for one cycle; no stage_start ever asserted.
- STALL_LIMIT=20, stage 5 never asserts stage_ready → deadlock=1 exactly 20 idle-handshake cycles after last fire; remains high; clears on reset.
- Assert ap_rst_n=0 mid-batch (frame 2 of 5) → all outputs return to reset values asynchronously; after release, new ap_start with frame_count=3 completes normally with frames_done=3.
